huff_seq_ctrl: RTL and testbench



---
 rtl/huff_pkg.sv | 19 +
 rtl/huff_sample_cnt.sv | 40 ++++
 rtl/huff_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_huff_seq_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman coding datapath: the state codes driven
// on the sequencer's state bus (also decoded by the symbol-count register
// bank) and the datapath sizing constants.
package huff_pkg;

   localparam int STATE_W = 3;   // width of the datapath state bus
   localparam int CNT_W   = 15;  // width of one symbol-count register
   localparam int SYM_NUM = 6;   // number of distinct symbols being coded

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      COUNT  = 3'd1,
      SORT   = 3'd2,
      PE     = 3'd3,
      SPLIT  = 3'd4,
      FINISH = 3'd5
   } huff_state_e;

endpackage

// File: rtl/huff_sample_cnt.sv
// Saturating gray-sample counter for one image plus the drain-cycle flag.
// o_done rises one cycle after the count first shows NUM_SAMPLES while the
// sequencer is in COUNT; that extra cycle lets the datapath's input register
// deliver the last sample to the count bank before sorting starts.
module huff_sample_cnt #(
   parameter int NUM_SAMPLES = 100
)(
   input  logic clk,
   input  logic reset,
   input  logic i_start,     // first sample of an image, accepted in IDLE
   input  logic i_count,     // further sample accepted in COUNT
   input  logic i_in_count,  // sequencer is in COUNT
   input  logic i_clear,     // end of image, return to zero
   output logic o_done
);

   localparam logic [7:0] LAST_SAMPLE = 8'(NUM_SAMPLES);

   logic [7:0] r_cnt;
   logic       r_drain;

   // Count accepted samples (saturating) and flag the drain cycle once full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_drain <= 1'b0;
      end else begin
         if (i_clear)
            r_cnt <= '0;
         else if (i_start)
            r_cnt <= 8'd1;
         else if (i_count && (r_cnt != LAST_SAMPLE))
            r_cnt <= r_cnt + 8'd1;
         r_drain <= i_in_count && (r_cnt == LAST_SAMPLE);
      end
   end

   assign o_done = r_drain;

endmodule

// File: rtl/huff_seq_ctrl.sv
// Top-level sequencer for the Huffman coding datapath: counts one image of
// gray samples, runs NUM_ROUNDS sort/combine rounds and NUM_ROUNDS split
// rounds, then flags the codes final and returns to IDLE.
// Optional build macro HUFF_SORT_TIMEOUT_EN adds a bounded wait for sort_done
// with a sticky o_err flag; without it SORT waits indefinitely.
//
// Handshake: i_gray_valid and i_sort_done are single-cycle qualifiers with no
// backpressure; each is acted on only in the state that expects it and is
// ignored everywhere else. o_sort_start, o_cnt_valid and o_code_valid are
// one-cycle pulses that the consumer must take when they are high.
module huff_seq_ctrl
   import huff_pkg::*;
#(
   parameter int NUM_SAMPLES  = 100,
   parameter int NUM_ROUNDS   = 4
`ifdef HUFF_SORT_TIMEOUT_EN
  ,parameter int SORT_TIMEOUT = 15
`endif
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_gray_valid,
   input  logic               i_sort_done,
   output logic [STATE_W-1:0] o_state,
   output logic               o_sort_start,
   output logic [2:0]         o_round,
   output logic               o_cnt_valid,
   output logic               o_code_valid,
   output logic               o_busy
`ifdef HUFF_SORT_TIMEOUT_EN
  ,output logic               o_err
`endif
);

   localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);

   huff_state_e r_state, w_next;
   logic [2:0]  r_round, w_round_nxt;
   logic        r_sort_start, w_sort_start_nxt;
   logic        r_cnt_valid, w_cnt_valid_nxt;
   logic        r_code_valid, w_code_valid_nxt;
   logic        r_busy, w_busy_nxt;
   logic        w_done;
`ifdef HUFF_SORT_TIMEOUT_EN
   localparam logic [3:0] WAIT_LAST = 4'(SORT_TIMEOUT - 1);
   logic [3:0]  r_wait, w_wait_nxt;
   logic        r_err, w_err_nxt;
`endif

   huff_sample_cnt #(
      .NUM_SAMPLES (NUM_SAMPLES)
   ) u_sample_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_start    ((r_state == IDLE) && i_gray_valid),
      .i_count    ((r_state == COUNT) && i_gray_valid),
      .i_in_count (r_state == COUNT),
      .i_clear    (r_state == FINISH),
      .o_done     (w_done)
   );

   // State register plus the registered copies of every output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_round      <= '0;
         r_sort_start <= 1'b0;
         r_cnt_valid  <= 1'b0;
         r_code_valid <= 1'b0;
         r_busy       <= 1'b0;
`ifdef HUFF_SORT_TIMEOUT_EN
         r_wait       <= '0;
         r_err        <= 1'b0;
`endif
      end else begin
         r_state      <= w_next;
         r_round      <= w_round_nxt;
         r_sort_start <= w_sort_start_nxt;
         r_cnt_valid  <= w_cnt_valid_nxt;
         r_code_valid <= w_code_valid_nxt;
         r_busy       <= w_busy_nxt;
`ifdef HUFF_SORT_TIMEOUT_EN
         r_wait       <= w_wait_nxt;
         r_err        <= w_err_nxt;
`endif
      end
   end

   // Next-state decode; sort_done is ignored while sort_start is still high.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (i_gray_valid) w_next = COUNT;
         COUNT:  if (w_done) w_next = SORT;
         SORT: begin
            if (i_sort_done && !r_sort_start) w_next = PE;
`ifdef HUFF_SORT_TIMEOUT_EN
            else if (r_wait == WAIT_LAST) w_next = FINISH;
`endif
         end
         PE:     w_next = (r_round == LAST_ROUND) ? SPLIT : SORT;
         SPLIT:  if (r_round == LAST_ROUND) w_next = FINISH;
         FINISH: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Next values of the registered outputs, decoded from the transition.
   always_comb begin
      w_round_nxt      = r_round;
      w_sort_start_nxt = (w_next == SORT) && (r_state != SORT);
      w_cnt_valid_nxt  = (r_state == COUNT) && (w_next == SORT);
      w_code_valid_nxt = (w_next == FINISH);
      w_busy_nxt       = (w_next != IDLE);
      case (r_state)
         PE:     w_round_nxt = (r_round == LAST_ROUND) ? 3'd0 : r_round + 3'd1;
         SPLIT:  if (r_round != LAST_ROUND) w_round_nxt = r_round + 3'd1;
         FINISH: w_round_nxt = 3'd0;
         IDLE:   w_round_nxt = 3'd0;
         default: w_round_nxt = r_round;
      endcase
`ifdef HUFF_SORT_TIMEOUT_EN
      w_wait_nxt = ((r_state == SORT) && (w_next == SORT)) ? r_wait + 4'd1 : 4'd0;
      w_err_nxt  = r_err || ((r_state == SORT) && (w_next == FINISH));
`endif
   end

   assign o_state      = r_state;
   assign o_round      = r_round;
   assign o_sort_start = r_sort_start;
   assign o_cnt_valid  = r_cnt_valid;
   assign o_code_valid = r_code_valid;
   assign o_busy       = r_busy;
`ifdef HUFF_SORT_TIMEOUT_EN
   assign o_err        = r_err;
`endif

endmodule

// File: tb/tb_huff_seq_ctrl.sv
// Bench for huff_seq_ctrl. A planner lays out whole images as per-cycle input
// schedules and derives, from the sequencing rules, the expected state/round
// per cycle and the expected pulse events (cycle, kind, round). A driver
// replays the schedule; a monitor compares every cycle and pops pulse events.
module tb_huff_seq_ctrl;

   localparam int NS   = 100;
   localparam int NR   = 4;
   localparam int TO   = 15;
   localparam int MAXC = 4096;
   localparam int K_CNT  = 0;
   localparam int K_SORT = 1;
   localparam int K_CODE = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_gray_valid = 1'b0;
   logic       i_sort_done = 1'b0;
   logic [2:0] o_state, o_round;
   logic       o_sort_start, o_cnt_valid, o_code_valid, o_busy;
`ifdef HUFF_SORT_TIMEOUT_EN
   logic       o_err;
   logic       e_err [MAXC];
`endif

   huff_seq_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .i_gray_valid (i_gray_valid),
      .i_sort_done  (i_sort_done),
      .o_state      (o_state),
      .o_sort_start (o_sort_start),
      .o_round      (o_round),
      .o_cnt_valid  (o_cnt_valid),
      .o_code_valid (o_code_valid),
      .o_busy       (o_busy)
`ifdef HUFF_SORT_TIMEOUT_EN
     ,.o_err        (o_err)
`endif
   );

   // clock / cycle index
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        p_gv [MAXC];
   logic        p_sd [MAXC];
   logic        p_rst [MAXC];
   int          e_state [MAXC];
   int          e_round [MAXC];
   logic [20:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          end_cyc = 0;

   function automatic logic [20:0] pack(input int c, input int k, input int r);
      return {c[15:0], k[1:0], r[2:0]};
   endfunction

   task automatic finish_at(input int c);
      e_state[c] = 5;
      e_round[c] = -1;
      exp_q.push_back(pack(c, K_CODE, 0));
   endtask

   // Plan one image starting with its first sample in cycle t.
   task automatic plan_image(input int t, input int gap_len, input int fixed_d,
                             input int abort_pe, input int to_round, input bit noise,
                             output int nxt);
      int  c, k_last, gap_at, cur, s, d, p, hi;
      bit  done;
      c = t; k_last = t; gap_at = $urandom_range(10, 90); done = 1'b0;
      for (int i = 0; i < NS; i++) begin
         if (gap_len > 0 && i == gap_at) c += gap_len;
         p_gv[c] = 1'b1;
         k_last = c;
         c++;
      end
      // last sample registers in k_last+1, drain cycle k_last+2
      for (int i = t + 1; i <= k_last + 2; i++) e_state[i] = 1;
      exp_q.push_back(pack(k_last + 3, K_CNT, 0));
      cur = k_last + 3; hi = cur; nxt = cur;
      for (int r = 0; r < NR && !done; r++) begin
         s = cur;
         exp_q.push_back(pack(s, K_SORT, r));
         if (noise && $urandom_range(0, 1) == 1) p_sd[s] = 1'b1;
         if (r == to_round) begin
            for (int i = s; i < s + TO; i++) begin e_state[i] = 2; e_round[i] = r; end
            hi = s + TO;
            finish_at(hi);
`ifdef HUFF_SORT_TIMEOUT_EN
            for (int i = hi; i < MAXC; i++) e_err[i] = 1'b1;
`endif
            nxt = hi + 1;
            done = 1'b1;
         end else begin
            d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 4));
            p_sd[s + d] = 1'b1;
            for (int i = s; i <= s + d; i++) begin e_state[i] = 2; e_round[i] = r; end
            p = s + d + 1;
            e_state[p] = 3; e_round[p] = r;
            if (r == abort_pe) begin
               p_rst[p] = 1'b1; p_rst[p + 1] = 1'b1;
               hi = p; nxt = p + 3; done = 1'b1;
            end else begin
               cur = p + 1;
            end
         end
      end
      if (!done) begin
         for (int r = 0; r < NR; r++) begin
            e_state[cur + r] = 4; e_round[cur + r] = r;
            if (noise && $urandom_range(0, 1) == 1) p_sd[cur + r] = 1'b1;
         end
         hi = cur + NR;
         finish_at(hi);
         nxt = hi + 1;
      end
      if (noise)
         for (int i = k_last + 1; i <= hi; i++)
            if ($urandom_range(0, 3) == 0) p_gv[i] = 1'b1;
   endtask

   task automatic chk_pulse(input int k, input logic [2:0] r);
      logic [20:0] got, want;
      n_checks++;
      got = pack(cyc, k, (k == K_SORT) ? int'(r) : 0);
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL pulse: kind=%0d at cycle %0d round %0d, expected no pulse", k, cyc, r);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            n_fail++;
            $display("FAIL pulse: got cycle=%0d kind=%0d round=%0d, expected cycle=%0d kind=%0d round=%0d",
                     got[20:5], got[4:3], got[2:0], want[20:5], want[4:3], want[2:0]);
         end
      end
   endtask

   // monitor: sample well after the active edge
   always @(posedge clk) begin
      #2;
      if (cyc < end_cyc) begin
         n_checks++;
         if (o_state !== 3'(e_state[cyc]) || o_busy !== (e_state[cyc] != 0) ||
             (e_round[cyc] >= 0 && o_round !== 3'(e_round[cyc]))) begin
            n_fail++;
            $display("FAIL trace cycle %0d: state=%0d busy=%0b round=%0d, expected state=%0d busy=%0b round=%0d",
                     cyc, o_state, o_busy, o_round, e_state[cyc], e_state[cyc] != 0, e_round[cyc]);
         end
`ifdef HUFF_SORT_TIMEOUT_EN
         n_checks++;
         if (o_err !== e_err[cyc]) begin
            n_fail++;
            $display("FAIL err cycle %0d: got %0b expected %0b", cyc, o_err, e_err[cyc]);
         end
`endif
         if (o_cnt_valid === 1'b1)  chk_pulse(K_CNT, o_round);
         if (o_sort_start === 1'b1) chk_pulse(K_SORT, o_round);
         if (o_code_valid === 1'b1) chk_pulse(K_CODE, o_round);
      end
   end

   // planner + driver
   initial begin
      int t, nxt;
      for (int i = 0; i < MAXC; i++) begin
         p_gv[i] = 1'b0; p_sd[i] = 1'b0; p_rst[i] = 1'b0;
         e_state[i] = 0; e_round[i] = 0;
`ifdef HUFF_SORT_TIMEOUT_EN
         e_err[i] = 1'b0;
`endif
      end
      for (int i = 0; i < 3; i++) p_rst[i] = 1'b1;
      // A: 100 back-to-back samples, sort_done two cycles after each sort_start
      plan_image(5, 0, 2, -1, -1, 1'b0, nxt);
      // B: 5-cycle gap mid-image, coincident sort_done and stray inputs
      t = nxt + 3;
      plan_image(t, 5, 0, -1, -1, 1'b1, nxt);
      // C: reset during the third PE
      t = nxt + 2;
      plan_image(t, 0, 0, 2, -1, 1'b1, nxt);
      // D onward: normal images after the abort, random gaps and delays
      for (int n = 0; n < 3; n++) begin
         t = nxt + int'($urandom_range(1, 6));
         plan_image(t, int'($urandom_range(0, 7)), 0, -1, -1, 1'b1, nxt);
      end
`ifdef HUFF_SORT_TIMEOUT_EN
      t = nxt + 2;
      plan_image(t, 0, 0, -1, int'($urandom_range(0, NR - 1)), 1'b1, nxt);
      t = nxt + 3;
      plan_image(t, 0, 0, -1, -1, 1'b0, nxt);
`endif
      end_cyc = nxt + 6;
      while (cyc < end_cyc) begin
         @(negedge clk);
         reset        = p_rst[cyc];
         i_gray_valid = p_gv[cyc];
         i_sort_done  = p_sd[cyc];
      end
      @(posedge clk);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending pulses: %0d left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
